// File: rtl/coco_muldiv_pkg.sv
// coco_muldiv_pkg: shared codes for the ALU and the iterative mult/div unit
package coco_muldiv_pkg;
  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_XOR = 4'd4;
  localparam logic [3:0] ALU_NOR = 4'd5;
  localparam logic [3:0] ALU_SLT = 4'd6;
  localparam logic [3:0] ALU_SLL = 4'd7;
  localparam logic [3:0] ALU_SRL = 4'd8;
  localparam logic [3:0] ALU_SRA = 4'd9;
  localparam int MD_ITERS = 32;
  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } md_op_e;
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } md_state_e;
  function automatic logic is_muldiv(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction
  function automatic logic is_signed_op(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction
endpackage

// File: rtl/coco_muldiv_abs.sv
// coco_muldiv_abs: 32-bit conditional two's-complement negate
module coco_muldiv_abs (
  input  logic [31:0] a_i,
  input  logic        neg_i,
  output logic [31:0] y_o
);
  always_comb y_o = neg_i ? (~a_i + 32'd1) : a_i;
endmodule

// File: rtl/coco_muldiv.sv
// coco_muldiv: iterative 32-cycle shift-add multiplier / restoring divider owning HI and LO
module coco_muldiv
  import coco_muldiv_pkg::*;
(
  input  logic        Clk,
  input  logic        Rst,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [2:0]  Op,
  input  logic        Start,
  output logic        Busy,
  output logic [31:0] Hi,
  output logic [31:0] Lo
);
  md_state_e   state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [63:0] pr_q, pr_d, calc_pr;
  logic [31:0] md_q, md_d, hi_q, hi_d, lo_q, lo_d;
  logic        mul_q, mul_d, sa_q, sa_d, sb_q, sb_d;
  logic        go, wr_res, sgn, neg_res, ge;
  logic [31:0] a_mag, b_mag, lo_fix, hi_fix, hi_res, sub_r;
  logic [32:0] add_s, sub_t;
  assign sgn = is_signed_op(Op);
  assign go = Start && is_muldiv(Op);
  assign neg_res = sa_q ^ sb_q;
  coco_muldiv_abs u_abs_a (.a_i(A), .neg_i(sgn & A[31]), .y_o(a_mag));
  coco_muldiv_abs u_abs_b (.a_i(B), .neg_i(sgn & B[31]), .y_o(b_mag));
  coco_muldiv_abs u_fix_lo (.a_i(pr_q[31:0]), .neg_i(neg_res), .y_o(lo_fix));
  // a 64-bit negate only carries into the high word when the low word is zero
  coco_muldiv_abs u_fix_hi (
    .a_i  (pr_q[63:32]),
    .neg_i(mul_q ? (neg_res && pr_q[31:0] == 32'd0) : sa_q),
    .y_o  (hi_fix)
  );
  assign hi_res = (mul_q && neg_res && pr_q[31:0] != 32'd0) ? ~pr_q[63:32] : hi_fix;
  always_ff @(posedge Clk) state_q <= Rst ? S_IDLE : state_d;
  always_comb begin
    state_d = (state_q == S_IDLE) ? (go ? S_CALC : S_IDLE) :
              (state_q == S_CALC) ? ((cnt_q == 6'(MD_ITERS - 1)) ? S_FIX : S_CALC) : S_IDLE;
  end
  always_comb begin
    Busy = state_q != S_IDLE;
    wr_res = state_q == S_FIX;
    Hi = hi_q;
    Lo = lo_q;
  end
  // multiply: {acc, multiplier} shifts right; divide: {rem, quot} shifts left
  always_comb begin
    add_s = {1'b0, pr_q[63:32]} + (pr_q[0] ? {1'b0, md_q} : 33'd0);
    sub_t = {pr_q[63:32], pr_q[31]};
    ge = sub_t >= {1'b0, md_q};
    sub_r = sub_t[31:0] - md_q;
    calc_pr = mul_q ? {add_s, pr_q[31:1]} :
              ge ? {sub_r, pr_q[30:0], 1'b1} : {sub_t[31:0], pr_q[30:0], 1'b0};
  end
  always_comb begin
    cnt_d = (state_q == S_CALC) ? cnt_q + 6'd1 : 6'd0;
    pr_d = pr_q;
    md_d = md_q;
    mul_d = mul_q;
    sa_d = sa_q;
    sb_d = sb_q;
    hi_d = hi_q;
    lo_d = lo_q;
    if (state_q == S_IDLE && go) begin
      mul_d = (Op == OP_MULT) || (Op == OP_MULTU);
      sa_d = sgn & A[31];
      sb_d = sgn & B[31];
      pr_d = {32'd0, mul_d ? b_mag : a_mag};
      md_d = mul_d ? a_mag : b_mag;
    end else if (state_q == S_CALC) begin
      pr_d = calc_pr;
    end
    if (wr_res) begin
      hi_d = hi_res;
      lo_d = lo_fix;
    end else if (state_q == S_IDLE && Start && Op == OP_MTHI) begin
      hi_d = A;
    end else if (state_q == S_IDLE && Start && Op == OP_MTLO) begin
      lo_d = A;
    end
  end
  always_ff @(posedge Clk) begin
    if (Rst) begin
      cnt_q <= '0;
      pr_q <= '0;
      md_q <= '0;
      mul_q <= 1'b0;
      sa_q <= 1'b0;
      sb_q <= 1'b0;
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      pr_q <= pr_d;
      md_q <= md_d;
      mul_q <= mul_d;
      sa_q <= sa_d;
      sb_q <= sb_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end
endmodule

// File: doc/coco_muldiv.md
COCO_MULDIV -- requirements
Module: coco_muldiv

Interface
REQ-001 SHALL expose ports, one per line, clock and reset first:
- Clk  in  1  sole clock; all state updates on rising edge
- Rst  in  1  synchronous, active-high reset
- A  in  32  operand 1 (rs): multiplicand/dividend, or MTHI/MTLO data
- B  in  32  operand 2 (rt): multiplier/divisor
- Op  in  3  operation: MULT, MULTU, DIV, DIVU, MTHI, MTLO
- Start  in  1  one-cycle request; A, B, Op sampled on the same edge
- Busy  out  1  high while a mult/div is in flight
- Hi  out  32  architectural HI register
- Lo  out  32  architectural LO register
REQ-002 SHALL use one clock; reset is synchronous and active-high.

Function
REQ-003 SHALL implement FSM states IDLE, CALC, FIX.
- IDLE -> CALC on Start with Op in {MULT, MULTU, DIV, DIVU}.
- CALC -> FIX after exactly 32 iterations.
- FIX -> IDLE unconditionally.
REQ-004 SHALL assert Busy from the cycle after Start is accepted through the FIX cycle inclusive: 33 cycles.
REQ-005 SHALL make the new Hi/Lo visible on the first cycle Busy is low again.
REQ-006 SHALL ignore Start while Busy is high, whatever the Op; no queuing.
REQ-007 SHALL, on Start with MTHI or MTLO in IDLE, write A into Hi or Lo at that edge, with no Busy pulse.
REQ-008 SHALL compute MULT/MULTU with an iterative shift-add over operand magnitudes, one bit per cycle.
- Result: {Hi,Lo} = 64-bit product, signed or unsigned per Op.
REQ-009 SHALL compute DIV/DIVU with 32-step restoring division on magnitudes.
- Lo = quotient truncated toward zero.
- Hi = remainder, taking the sign of the dividend.
REQ-010 SHALL apply signed fix-up (negate product, quotient and/or remainder) in the FIX state only.
REQ-011 SHALL, on divide by zero: Hi = A, Lo = 32'hFFFFFFFF (DIVU) or the sign-dependent value 32'hFFFFFFFF / 32'h00000001 (DIV, A non-negative / negative). Latency unchanged.
REQ-012 SHALL return Lo = 32'h80000000, Hi = 0 for DIV 32'h80000000 / 32'hFFFFFFFF. No overflow output, no exception.
REQ-013 SHALL hold Hi and Lo at their prior values throughout CALC and FIX; partial results stay in internal registers only.
REQ-014 SHALL hold Hi/Lo stable in IDLE absent an accepted Start.

Reset
REQ-015 SHALL, when Rst is high at a clock edge, force state IDLE, Busy=0, Hi=0, Lo=0, and clear the iteration counter and partial registers.
REQ-016 SHALL give Rst priority over Start and over any in-flight operation; a mid-operation reset discards the result and writes nothing to Hi/Lo.

Structure
REQ-017 SHALL take the Op encodings (MULT=0, MULTU=1, DIV=2, DIVU=3, MTHI=4, MTLO=5) and FSM state encodings from the shared define file, alongside the existing ALU control codes.
REQ-018 SHALL use a 6-bit iteration counter and a 64-bit partial product / remainder-quotient register pair; no hardware multiplier primitive.
REQ-019 SHALL use one sub-module, coco_muldiv_abs: 32-bit conditional two's-complement negate, instanced for operand magnitudes and fix-up.

Verification
REQ-020 Scenario: MULTU A=32'hFFFFFFFF, B=32'hFFFFFFFF -> after 33 Busy cycles: Hi=32'hFFFFFFFE, Lo=32'h00000001.
REQ-021 Scenario: MULT A=-7 (32'hFFFFFFF9), B=3 -> Hi=32'hFFFFFFFF, Lo=32'hFFFFFFEB.
REQ-022 Scenario: DIV A=-7, B=2 -> Lo=32'hFFFFFFFD, Hi=32'hFFFFFFFF; then DIVU A=7, B=0 -> Lo=32'hFFFFFFFF, Hi=7.
REQ-023 Scenario: DIVU A=100, B=7 started; second Start (MTHI A=5) issued on cycle 10 -> second Start ignored; final Hi=2, Lo=14.
REQ-024 Scenario: MULT started, Rst asserted on cycle 15 -> next cycle Busy=0, Hi=0, Lo=0; a subsequent MTLO A=9 gives Lo=9 one cycle later.
REQ-025 Scenario: DIV A=32'h80000000, B=32'hFFFFFFFF -> Lo=32'h80000000, Hi=0, Busy exactly 33 cycles.
